// File: rtl/cpu_pkg.sv
// Shared CPU constants: default datapath widths and architectural register numbers
// used by the register file and the decode stage.
package cpu_pkg;

  localparam int CPU_DW = 32;
  localparam int CPU_AW = 5;

  // Architectural register numbers
  localparam int REG_ZERO = 0;
  localparam int REG_GP   = 28;
  localparam int REG_SP   = 29;
  localparam int REG_FP   = 30;
  localparam int REG_RA   = 31;

  // Number of entries addressed by a register number of the given width
  function automatic int numRegs(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/regfile_wdec.sv
// One-hot write decoder for the register file: turns a register number plus a
// write enable into per-entry load enables. The zero register never gets one.
module regfile_wdec
  import cpu_pkg::*;
#(
  parameter int AW = CPU_AW
) (
  input  logic                 we_i,
  input  logic [AW-1:0]        wn_i,
  output logic [(1<<AW)-1:0]   wen_o
);

  // Decode the register number when writing; entry 0 is forced off
  always_comb begin
    wen_o = '0;
    if (we_i) begin
      wen_o[wn_i] = 1'b1;
    end
    wen_o[REG_ZERO] = 1'b0;
  end

endmodule

// File: rtl/regfile_2r1w.sv
// CPU general-purpose register file: 2^AW entries of DW bits, two combinational
// read ports feeding decode, one clocked write port from write-back.
// Entry 0 is a constant zero. Optional write-first forwarding on both read ports.
module regfile_2r1w
  import cpu_pkg::*;
#(
  parameter int DW     = CPU_DW,
  parameter int AW     = CPU_AW,
  parameter bit BYPASS = 1'b1
) (
  input  logic          Clk,
  input  logic          Clrn,
  input  logic          We,
  input  logic [AW-1:0] Wn,
  input  logic [DW-1:0] D,
  input  logic [AW-1:0] Rna,
  input  logic [AW-1:0] Rnb,
  output logic [DW-1:0] Qa,
  output logic [DW-1:0] Qb
);

  localparam int NREGS = 1 << AW;

  logic [NREGS-1:0]         wen;
  logic [NREGS-1:0][DW-1:0] entries;
  logic [DW-1:0]            storedA;
  logic [DW-1:0]            storedB;

  regfile_wdec #(.AW(AW)) u_wdec (
    .we_i  (We),
    .wn_i  (Wn),
    .wen_o (wen)
  );

  for (genvar g = 0; g < NREGS; g++) begin : gEntry
    if (g == REG_ZERO) begin : gZero
      // No storage for the zero register. Its decoder enable is always low,
      // so masking with it still yields a constant zero slot.
      assign entries[g] = {DW{1'b0}} & {DW{wen[g]}};
    end else begin : gReg
      logic [DW-1:0] entry_d;
      logic [DW-1:0] entry_q;

      assign entry_d = wen[g] ? D : entry_q;

      // Entry storage: loads on its decoder enable, cleared at once by reset
      always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
          entry_q <= '0;
        end else begin
          entry_q <= entry_d;
        end
      end

      assign entries[g] = entry_q;
    end
  end

  // Read muxes select stored state; slot 0 already reads as zero
  assign storedA = entries[Rna];
  assign storedB = entries[Rnb];

  if (BYPASS) begin : gBypass
    logic fwdA;
    logic fwdB;

    // Forward the incoming write data when it targets the register being
    // read, so decode sees the write-back value in the same cycle.
    // Reset and the zero register both disable forwarding.
    always_comb begin
      fwdA = Clrn && We && (Wn != '0) && (Wn == Rna);
      fwdB = Clrn && We && (Wn != '0) && (Wn == Rnb);
      Qa   = fwdA ? D : storedA;
      Qb   = fwdB ? D : storedB;
    end
  end else begin : gNoBypass
    assign Qa = storedA;
    assign Qb = storedB;
  end

endmodule
